// File: rtl/digital_pfd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : digital_pfd
// Brief   : Sampled phase/frequency detector with signed phase error and lock.
// Revision: 1.0
// ============================================================================
module digital_pfd #(
    parameter int ERR_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_TOL    = 1,
    parameter int LOCK_CNT    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             ref_in,
    input  logic             fb_in,
    output logic             up,
    output logic             dn,
    output logic [ERR_W-1:0] phase_err,
    output logic             err_valid,
    output logic             lock
);

    localparam logic [ERR_W-1:0] c_SAT      = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic [ERR_W-1:0] c_ONE      = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] c_TOL      = ERR_W'(LOCK_TOL);
    localparam int               c_ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [c_ARM_W-1:0] c_ARM_DONE = c_ARM_W'(SYNC_STAGES + 1);
    localparam int               c_LCK_W    = $clog2(LOCK_CNT + 1);
    localparam logic [c_LCK_W-1:0] c_LCK_MAX  = c_LCK_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LEAD_REF = 2'd1,
        S_LEAD_FB  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Synchronisers, edge detection and post-reset arming window
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_ref_sync;
    logic [SYNC_STAGES-1:0] r_fb_sync;
    logic                   r_ref_prev;
    logic                   r_fb_prev;
    logic [c_ARM_W-1:0]     r_arm_cnt;
    logic                   w_armed;
    logic                   w_ref_edge;
    logic                   w_fb_edge;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ref_sync <= '0;
            r_fb_sync  <= '0;
            r_ref_prev <= 1'b0;
            r_fb_prev  <= 1'b0;
            r_arm_cnt  <= '0;
        end else begin
            r_ref_sync <= {r_ref_sync[SYNC_STAGES-2:0], ref_in};
            r_fb_sync  <= {r_fb_sync[SYNC_STAGES-2:0], fb_in};
            r_ref_prev <= r_ref_sync[SYNC_STAGES-1];
            r_fb_prev  <= r_fb_sync[SYNC_STAGES-1];
            if (r_arm_cnt != c_ARM_DONE) begin
                r_arm_cnt <= r_arm_cnt + 1'b1;
            end
        end
    end

    // Until prev has caught up with the chain, a level already high at release
    // would look like an edge; the arming window hides it.
    assign w_armed    = (r_arm_cnt == c_ARM_DONE);
    assign w_ref_edge = w_armed & r_ref_sync[SYNC_STAGES-1] & ~r_ref_prev;
    assign w_fb_edge  = w_armed & r_fb_sync[SYNC_STAGES-1] & ~r_fb_prev;

    // ------------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [ERR_W-1:0] r_cnt;
    logic [ERR_W-1:0] w_cnt_nxt;
    logic [ERR_W-1:0] w_cnt_inc;
    logic [ERR_W-1:0] r_phase_err;
    logic [ERR_W-1:0] w_err_nxt;
    logic             r_err_valid;
    logic             w_valid_nxt;
    logic             r_err_sat;
    logic             w_sat_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_phase_err <= '0;
            r_err_valid <= 1'b0;
            r_err_sat   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_phase_err <= w_err_nxt;
            r_err_valid <= w_valid_nxt;
            r_err_sat   <= w_sat_nxt;
        end
    end

    assign w_cnt_inc = (r_cnt == c_SAT) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_phase_err;
        w_valid_nxt = 1'b0;
        w_sat_nxt   = r_err_sat;
        if (!en) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ref_edge && w_fb_edge) begin
                        w_err_nxt   = '0;
                        w_valid_nxt = 1'b1;
                        w_sat_nxt   = 1'b0;
                    end else if (w_ref_edge) begin
                        w_state_nxt = S_LEAD_REF;
                        w_cnt_nxt   = c_ONE;
                    end else if (w_fb_edge) begin
                        w_state_nxt = S_LEAD_FB;
                        w_cnt_nxt   = c_ONE;
                    end
                end
                S_LEAD_REF: begin
                    if (w_fb_edge) begin
                        w_err_nxt   = r_cnt;
                        w_valid_nxt = 1'b1;
                        w_sat_nxt   = (r_cnt == c_SAT);
                        // A coincident ref edge opens the next measurement at once.
                        if (w_ref_edge) begin
                            w_cnt_nxt = c_ONE;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                        end
                    end else if (w_ref_edge) begin
                        w_err_nxt   = c_SAT;
                        w_valid_nxt = 1'b1;
                        w_sat_nxt   = 1'b1;
                        w_cnt_nxt   = c_ONE;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                S_LEAD_FB: begin
                    if (w_ref_edge) begin
                        w_err_nxt   = ~r_cnt + 1'b1;
                        w_valid_nxt = 1'b1;
                        w_sat_nxt   = (r_cnt == c_SAT);
                        if (w_fb_edge) begin
                            w_cnt_nxt = c_ONE;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                        end
                    end else if (w_fb_edge) begin
                        w_err_nxt   = ~c_SAT + 1'b1;
                        w_valid_nxt = 1'b1;
                        w_sat_nxt   = 1'b1;
                        w_cnt_nxt   = c_ONE;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Lock detector: evaluates each published error
    // ------------------------------------------------------------------------
    logic [ERR_W-1:0]   w_err_abs;
    logic               w_in_window;
    logic [c_LCK_W-1:0] r_lock_cnt;
    logic               r_lock;

    assign w_err_abs   = r_phase_err[ERR_W-1] ? (~r_phase_err + 1'b1) : r_phase_err;
    assign w_in_window = !r_err_sat && (w_err_abs <= c_TOL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock_cnt <= '0;
            r_lock     <= 1'b0;
        end else if (!en) begin
            r_lock_cnt <= '0;
            r_lock     <= 1'b0;
        end else if (r_err_valid && !w_in_window) begin
            r_lock_cnt <= '0;
            r_lock     <= 1'b0;
        end else begin
            if (r_err_valid && (r_lock_cnt != c_LCK_MAX)) begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end
            r_lock <= (r_lock_cnt == c_LCK_MAX);
        end
    end

    assign up        = (r_state == S_LEAD_REF);
    assign dn        = (r_state == S_LEAD_FB);
    assign phase_err = r_phase_err;
    assign err_valid = r_err_valid;
    assign lock      = r_lock;

endmodule
`default_nettype wire

// File: tb/tb_digital_pfd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_digital_pfd
// Brief   : Randomised scoreboard bench for digital_pfd.
// Revision: 1.0
// ============================================================================
module tb_digital_pfd;

    localparam int c_SAT      = 127;
    localparam int c_LOCK_TOL = 1;
    localparam int c_LOCK_CNT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       ref_in;
    logic       fb_in;
    logic       up;
    logic       dn;
    logic [7:0] phase_err;
    logic       err_valid;
    logic       lock;

    always #5 clk = ~clk;

    digital_pfd #(
        .ERR_W(8), .SYNC_STAGES(2), .LOCK_TOL(c_LOCK_TOL), .LOCK_CNT(c_LOCK_CNT)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .ref_in(ref_in), .fb_in(fb_in),
        .up(up), .dn(dn), .phase_err(phase_err), .err_valid(err_valid), .lock(lock)
    );

    typedef struct {
        int err;
        int upc;
        int dnc;
        bit lock_before;
        bit out_win;
    } exp_t;

    exp_t q[$];
    int   run       = 0;
    int   last_err  = 0;
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   up_cnt    = 0;
    int   dn_cnt    = 0;
    bit   both_seen = 1'b0;
    bit   pend_clr  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: error is the signed edge separation, lock is a run of
    // LOCK_CNT consecutive small, non-saturated errors.
    task automatic expect_strobe(input int d, input int upc, input int dnc, input bit sat);
        exp_t e;
        bit   inwin;
        inwin         = !sat && (d <= c_LOCK_TOL) && (d >= -c_LOCK_TOL);
        e.err         = d;
        e.upc         = upc;
        e.dnc         = dnc;
        e.lock_before = (run >= c_LOCK_CNT);
        e.out_win     = !inwin;
        run           = inwin ? ((run < c_LOCK_CNT) ? run + 1 : run) : 0;
        last_err      = d;
        q.push_back(e);
    endtask

    // d > 0: fb rises d cycles after ref; d < 0: ref rises -d cycles after fb.
    task automatic trial(input int d);
        int r0, f0, span;
        r0   = (d < 0) ? -d : 0;
        f0   = (d > 0) ? d : 0;
        span = ((r0 > f0) ? r0 : f0) + 3;
        expect_strobe(d, f0, r0, 1'b0);
        for (int c = 0; c < span; c++) begin
            ref_in = (c >= r0) && (c < r0 + 3);
            fb_in  = (c >= f0) && (c < f0 + 3);
            tick();
        end
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (25) tick();
    endtask

    // Two ref edges 10 cycles apart, then fb k cycles after the second one.
    task automatic slip(input int k);
        expect_strobe(c_SAT, 10, 0, 1'b1);
        expect_strobe(k, k, 0, 1'b0);
        for (int c = 0; c < 13 + k; c++) begin
            ref_in = (c < 3) || ((c >= 10) && (c < 13));
            fb_in  = (c >= 10 + k) && (c < 13 + k);
            tick();
        end
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (25) tick();
    endtask

    // Monitor: pops one expectation per strobe and checks pulse widths and lock.
    always @(negedge clk) begin
        if (reset || !en) begin
            up_cnt   = 0;
            dn_cnt   = 0;
            pend_clr = 1'b0;
        end else begin
            exp_t e;
            if (up && dn) both_seen = 1'b1;
            if (pend_clr) begin
                chk("lock_clear_after_out_of_window", int'(lock), 0);
                pend_clr = 1'b0;
            end
            if (err_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_err_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("phase_err", int'($signed(phase_err)), e.err);
                    chk("up_cycles", up_cnt, e.upc);
                    chk("dn_cycles", dn_cnt, e.dnc);
                    chk("lock_at_strobe", int'(lock), int'(e.lock_before));
                    pend_clr = e.out_win;
                end
                up_cnt = int'(up);
                dn_cnt = int'(dn);
            end else begin
                up_cnt += int'(up);
                dn_cnt += int'(dn);
            end
        end
    end

    initial begin
        reset  = 1'b1;
        en     = 1'b1;
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_up", int'(up), 0);
        chk("reset_dn", int'(dn), 0);
        chk("reset_phase_err", int'(phase_err), 0);
        chk("reset_err_valid", int'(err_valid), 0);
        chk("reset_lock", int'(lock), 0);
        reset = 1'b0;
        run   = 0;
        repeat (10) tick();

        trial(5);
        trial(-3);
        trial(0);
        slip(5);

        trial(1); trial(0); trial(-1); trial(1);
        chk("lock_after_four", int'(lock), 1);
        trial(3);
        chk("lock_after_plus3", int'(lock), 0);

        trial(0); trial(1); trial(-1); trial(0);
        chk("relock", int'(lock), 1);

        // Disable mid-measurement: everything clears except phase_err.
        for (int c = 0; c < 3; c++) begin
            ref_in = 1'b1;
            tick();
        end
        ref_in = 1'b0;
        repeat (3) tick();
        chk("up_before_disable", int'(up), 1);
        en = 1'b0;
        tick();
        chk("disable_up", int'(up), 0);
        chk("disable_lock", int'(lock), 0);
        chk("disable_err_valid", int'(err_valid), 0);
        chk("disable_phase_err_hold", int'($signed(phase_err)), last_err);
        fb_in = 1'b1;
        repeat (3) tick();
        fb_in = 1'b0;
        repeat (5) tick();
        en  = 1'b1;
        run = 0;
        repeat (20) tick();

        trial(0); trial(-1); trial(1); trial(0);
        chk("lock_before_reset", int'(lock), 1);

        // Asynchronous reset with ref held high through release.
        ref_in = 1'b1;
        repeat (6) tick();
        chk("up_before_reset", int'(up), 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_up", int'(up), 0);
        chk("async_reset_err_valid", int'(err_valid), 0);
        chk("async_reset_lock", int'(lock), 0);
        repeat (3) tick();
        reset = 1'b0;
        run   = 0;
        repeat (20) tick();
        ref_in = 1'b0;
        repeat (5) tick();
        trial(4);

        for (int i = 0; i < 24; i++) begin
            if ((i % 6) == 5) slip(int'($urandom_range(15, 2)));
            else trial(int'($urandom_range(40, 0)) - 20);
        end

        repeat (30) tick();
        chk("queue_empty", q.size(), 0);
        chk("up_dn_exclusive", int'(both_seen), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
